// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I pipeline.
// The stage forwards operands, runs the ALU, resolves BEQ-style branches
// and holds the EX/MEM pipeline register.
// Optional build macro EXEC_MUL_EN enables an iterative 32-cycle shift-add
// multiplier for ALUControlE=1010. While the multiplier is active, StallE
// is asserted. Without the macro, StallE is tied to 0 and 1010 yields 0.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [3:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        MemReadM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  // Register indices are consumed by the hazard unit, not by this stage.
  logic unused_rs;
  assign unused_rs = ^{RS1_E, RS2_E};

  logic [31:0] src_a, fwd_b, src_b, alu_res;
  logic        bubble;

  // Forward muxes: 01 selects the writeback value, 10 selects the
  // instruction one ahead; 00/11 select the register file value.
  always_comb begin
    src_a = RD1_E;
    fwd_b = RD2_E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic        mul_start, mul_done;

  // A MUL only starts outside reset so that an asserted reset always
  // releases the stall, even with the MUL still present on the inputs.
  assign mul_start = rst && (ALUControlE == OP_MUL) && (state_q == S_IDLE);

  // Multiplier state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
    end
  end

  // Next state and shift-add datapath: one multiplier bit per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (mul_start) begin
        state_d = S_BUSY;
        cnt_d   = '0;
        ma_d    = src_a;
        mb_d    = src_b;
        acc_d   = '0;
      end
      S_BUSY: begin
        acc_d = acc_q + (mb_q[0] ? ma_q : 32'd0);
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stall and bubble while the product is still being formed
  always_comb begin
    StallE   = mul_start || (state_q == S_BUSY);
    bubble   = StallE;
    mul_done = (state_q == S_DONE);
  end
`else
  assign StallE = 1'b0;
  assign bubble = 1'b0;
`endif

  // ALU: 32-bit wrap-around arithmetic; unknown codes produce 0
  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLL:  alu_res = src_a << src_b[4:0];
      OP_SRL:  alu_res = src_a >> src_b[4:0];
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
      OP_SLT:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {31'd0, src_a < src_b};
      default: alu_res = '0;
    endcase
`ifdef EXEC_MUL_EN
    if (mul_done) alu_res = acc_q;
`endif
  end

  assign PCSrcE    = BranchE & (alu_res == 32'd0);
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM register: a bubble clears the control bits, data loads regardless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE  & ~bubble;
      MemWriteM  <= MemWriteE  & ~bubble;
      MemReadM   <= MemReadE   & ~bubble;
      ResultSrcM <= ResultSrcE & ~bubble;
      RD_M       <= RD_E;
      ALUResultM <= alu_res;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage. It covers reset, forwarding, the
// ALU ops, branches, the store path and, with EXEC_MUL_EN, the multiplier.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E, RS1_E, RS2_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM, PCSrcE, StallE;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;

  int nvec = 0;
  int nerr = 0;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .StallE(StallE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[17];

  logic        rw_r;
  logic [31:0] r32, pc_r, imm_r, p4_r;
  logic [4:0]  rd_r;

  initial begin
    vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[2]  = '{4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE};
    vecs[3]  = '{4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vecs[4]  = '{4'b0011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
    vecs[5]  = '{4'b0100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
    vecs[6]  = '{4'b0101, 32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[7]  = '{4'b0101, 32'h00000001, 32'h00000021, 32'h00000002};
    vecs[8]  = '{4'b0110, 32'h80000000, 32'h00000004, 32'h08000000};
    vecs[9]  = '{4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000};
    vecs[10] = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[11] = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[12] = '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    vecs[14] = '{4'b1011, 32'h12345678, 32'h00000001, 32'h00000000};
    vecs[15] = '{4'b1111, 32'h12345678, 32'h00000001, 32'h00000000};
    vecs[16] = '{4'b0111, 32'h40000000, 32'h0000001E, 32'h00000001};

    // Reset with random inputs, arranged so that the branch compares equal
    r32   = $urandom;
    pc_r  = $urandom;
    imm_r = $urandom;
    p4_r  = $urandom;
    rd_r  = 5'($urandom);
    rw_r  = 1'($urandom);
    RegWriteE = rw_r; ALUSrcE = 1'b0; MemWriteE = 1'b1; MemReadE = 1'b1;
    ResultSrcE = 1'b1; BranchE = 1'b1; ALUControlE = 4'b0001;
    RD1_E = r32; RD2_E = r32; Imm_Ext_E = imm_r; PCE = pc_r; PCPlus4E = p4_r;
    RD_E = rd_r; RS1_E = 5'($urandom); RS2_E = 5'($urandom);
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = $urandom;
    tick(); tick();
    check("rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    check("rst_MemWriteM", {31'd0, MemWriteM}, 32'd0);
    check("rst_MemReadM", {31'd0, MemReadM}, 32'd0);
    check("rst_ResultSrcM", {31'd0, ResultSrcM}, 32'd0);
    check("rst_RD_M", {27'd0, RD_M}, 32'd0);
    check("rst_ALUResultM", ALUResultM, 32'd0);
    check("rst_WriteDataM", WriteDataM, 32'd0);
    check("rst_PCPlus4M", PCPlus4M, 32'd0);
    check("rst_PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("rst_PCTargetE", PCTargetE, pc_r + imm_r);
    check("rst_StallE", {31'd0, StallE}, 32'd0);

    // Release: the next edge captures the inputs
    rst = 1'b1;
    tick();
    check("rel_RegWriteM", {31'd0, RegWriteM}, {31'd0, rw_r});
    check("rel_MemWriteM", {31'd0, MemWriteM}, 32'd1);
    check("rel_RD_M", {27'd0, RD_M}, {27'd0, rd_r});
    check("rel_ALUResultM", ALUResultM, 32'd0);
    check("rel_WriteDataM", WriteDataM, r32);
    check("rel_PCPlus4M", PCPlus4M, p4_r);

    // Forwarding: first produce ALUResultM = 7
    BranchE = 1'b0; MemWriteE = 1'b0; MemReadE = 1'b0; ResultSrcE = 1'b0;
    RegWriteE = 1'b1; ALUControlE = 4'b0000; RD1_E = 32'd3; RD2_E = 32'd4;
    tick();
    check("fwd_setup", ALUResultM, 32'd7);
    RD1_E = 32'd5; RD2_E = 32'd3; ResultW = 32'd9;
    ForwardAE = 2'b10; ForwardBE = 2'b01;
    tick();
    check("fwd_10_01", ALUResultM, 32'd16);
    check("fwd_wdata", WriteDataM, 32'd9);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    tick();
    check("fwd_00_00", ALUResultM, 32'd8);
    ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 32'd100;
    tick();
    check("fwd_11_11", ALUResultM, 32'd8);

    // ALU table through the immediate path; RD2_E is made distinct so a mux error shows up
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ALUControlE = vecs[i].op;
      RD1_E       = vecs[i].a;
      Imm_Ext_E   = vecs[i].b;
      RD2_E       = ~vecs[i].b;
      tick();
      check($sformatf("alu_%0d_op%b", i, vecs[i].op), ALUResultM, vecs[i].exp);
    end

    // Branch taken and not taken
    ALUSrcE = 1'b0; BranchE = 1'b1; ALUControlE = 4'b0001;
    RD1_E = 32'h10; RD2_E = 32'h10; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    check("br_taken", {31'd0, PCSrcE}, 32'd1);
    check("br_target", PCTargetE, 32'h120);
    RD2_E = 32'h11;
    #1;
    check("br_not_taken", {31'd0, PCSrcE}, 32'd0);
    BranchE = 1'b0; RD2_E = 32'h10;
    #1;
    check("br_nobranch", {31'd0, PCSrcE}, 32'd0);

    // Store path
    tick();
    MemWriteE = 1'b1; RegWriteE = 1'b0; ALUSrcE = 1'b1; ALUControlE = 4'b0000;
    RD1_E = 32'h1000; Imm_Ext_E = 32'd8; RD2_E = 32'hDEADBEEF; RD_E = 5'd17;
    tick();
    check("st_addr", ALUResultM, 32'h1008);
    check("st_wdata", WriteDataM, 32'hDEADBEEF);
    check("st_memwrite", {31'd0, MemWriteM}, 32'd1);
    check("st_regwrite", {31'd0, RegWriteM}, 32'd0);
    check("st_rd", {27'd0, RD_M}, 32'd17);

    // MUL code
    MemWriteE = 1'b0; RegWriteE = 1'b1; ALUSrcE = 1'b0; ALUControlE = 4'b1010;
    RD1_E = 32'h00012345; RD2_E = 32'h00000100;
`ifdef EXEC_MUL_EN
    for (int c = 0; c < 33; c++) begin
      if (c == 5) begin
        RD1_E = 32'hFFFFFFFF; RD2_E = 32'h55555555; ForwardAE = 2'b01;
      end
      check($sformatf("mul_stall_c%0d", c), {31'd0, StallE}, 32'd1);
      if (c > 0) check($sformatf("mul_nowrite_c%0d", c), {31'd0, RegWriteM}, 32'd0);
      tick();
    end
    check("mul_done_stall", {31'd0, StallE}, 32'd0);
    tick();
    check("mul_product", ALUResultM, 32'h01234500);
    check("mul_regwrite", {31'd0, RegWriteM}, 32'd1);

    // Reset during BUSY at count 10
    ForwardAE = 2'b00; ALUControlE = 4'b0000;
    tick();
    ALUControlE = 4'b1010;
    for (int c = 0; c < 11; c++) tick();
    check("mulrst_busy_stall", {31'd0, StallE}, 32'd1);
    rst = 1'b0;
    #1;
    check("mulrst_stall", {31'd0, StallE}, 32'd0);
    check("mulrst_regwrite", {31'd0, RegWriteM}, 32'd0);
    ALUControlE = 4'b0000; RegWriteE = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mulrst_after_stall", {31'd0, StallE}, 32'd0);
    check("mulrst_after_write", {31'd0, RegWriteM}, 32'd0);
`else
    #1;
    check("mul_off_stall", {31'd0, StallE}, 32'd0);
    tick();
    check("mul_off_result", ALUResultM, 32'd0);
    check("mul_off_regwrite", {31'd0, RegWriteM}, 32'd1);
    check("mul_off_stall2", {31'd0, StallE}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
